// File: rtl/hilo_mul_sequencer_pkg.sv
//------------------------------------------------------------------------------
// hilo_mul_sequencer_pkg: ALU control opcodes, sequencer states, op decode
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package hilo_mul_sequencer_pkg;

  localparam logic [5:0] OP_MULTU = 6'b000011;
  localparam logic [5:0] OP_MADD  = 6'b000100;
  localparam logic [5:0] OP_MSUB  = 6'b000101;
  localparam logic [5:0] OP_MTHI  = 6'b010100;
  localparam logic [5:0] OP_MTLO  = 6'b010101;
  localparam logic [5:0] OP_MFHI  = 6'b010110;
  localparam logic [5:0] OP_MFLO  = 6'b010111;
  localparam logic [5:0] OP_MULT  = 6'b011000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIX  = 2'd2,
    ST_ACC  = 2'd3
  } state_t;

  function automatic logic is_mul_op(input logic [5:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_mul_sequencer_if.sv
//------------------------------------------------------------------------------
// hilo_mul_sequencer_if: execute-stage handshake and HI/LO result bundle
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface hilo_mul_sequencer_if;
  logic        OpValid;
  logic        OpReady;
  logic [5:0]  OpCode;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output OpValid, OpCode, A, B,
    input  OpReady, ReadData, Stall, Busy, Done, HI, LO
  );

  modport slave (
    input  OpValid, OpCode, A, B,
    output OpReady, ReadData, Stall, Busy, Done, HI, LO
  );
endinterface

`default_nettype wire

// File: rtl/hilo_mul_sequencer_mul_iter_datapath.sv
//------------------------------------------------------------------------------
// mul_iter_datapath: radix-2^BITS_PER_CYCLE shift-add unsigned multiplier core
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mul_iter_datapath #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        negate,
  input  logic [31:0] mcand_in,
  input  logic [31:0] mplier_in,
  output logic [63:0] product,
  output logic        last_iter
);

  localparam int N  = 32 / BITS_PER_CYCLE;
  localparam int CW = 6;

  logic [63:0]   mcand;
  logic [31:0]   mplier;
  logic [CW-1:0] count;
  logic [63:0]   terms [BITS_PER_CYCLE];
  logic [63:0]   partial;

  // One gated, shifted copy of the multiplicand per multiplier bit retired.
  for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_pp
    assign terms[j] = mplier[j] ? (mcand << j) : 64'd0;
  end

  always_comb begin
    partial = 64'd0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      partial = partial + terms[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= 64'd0;
      mcand   <= 64'd0;
      mplier  <= 32'd0;
      count   <= '0;
    end else if (load) begin
      product <= 64'd0;
      mcand   <= {32'd0, mcand_in};
      mplier  <= mplier_in;
      count   <= CW'(N);
    end else if (step) begin
      product <= product + partial;
      mcand   <= mcand << BITS_PER_CYCLE;
      mplier  <= mplier >> BITS_PER_CYCLE;
      count   <= count - CW'(1);
    end else if (negate) begin
      product <= 64'd0 - product;
    end
  end

  assign last_iter = (count == CW'(1));

endmodule

`default_nettype wire

// File: rtl/hilo_mul_sequencer.sv
//------------------------------------------------------------------------------
// hilo_mul_sequencer: HI/LO owner, iterative MULT/MULTU/MADD/MSUB and MT/MF ops
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hilo_mul_sequencer
  import hilo_mul_sequencer_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  hilo_mul_sequencer_if.slave  bus
);

  state_t      state;
  state_t      state_next;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  op_q;
  logic        sign_q;
  logic        ready;
  logic        done;
  logic        accept;
  logic        dp_load;
  logic        dp_step;
  logic        dp_neg;
  logic        last_iter;
  logic [63:0] product;
  logic [63:0] acc_result;
  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] read_data;

  assign accept    = bus.OpValid & ready;
  assign signed_op = (bus.OpCode != OP_MULTU);
  assign mag_a     = (signed_op && bus.A[31]) ? (32'd0 - bus.A) : bus.A;
  assign mag_b     = (signed_op && bus.B[31]) ? (32'd0 - bus.B) : bus.B;

  mul_iter_datapath #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_datapath (
    .clk       (Clk),
    .rst       (Rst),
    .load      (dp_load),
    .step      (dp_step),
    .negate    (dp_neg),
    .mcand_in  (mag_a),
    .mplier_in (mag_b),
    .product   (product),
    .last_iter (last_iter)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    dp_neg     = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.OpValid && is_mul_op(bus.OpCode)) begin
          dp_load    = 1'b1;
          state_next = ST_MUL;
        end
      end
      ST_MUL: begin
        dp_step = 1'b1;
        if (last_iter) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        dp_neg     = sign_q;
        state_next = ST_ACC;
      end
      ST_ACC: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_MADD: acc_result = {hi, lo} + product;
      OP_MSUB: acc_result = {hi, lo} - product;
      default: acc_result = product;
    endcase
  end

  // Ops are only accepted in IDLE, so MT* writes and ACC commits never collide.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      op_q   <= 6'd0;
      sign_q <= 1'b0;
    end else begin
      if (dp_load) begin
        op_q   <= bus.OpCode;
        sign_q <= signed_op & (bus.A[31] ^ bus.B[31]);
      end
      if (accept && bus.OpCode == OP_MTHI) begin
        hi <= bus.A;
      end else if (accept && bus.OpCode == OP_MTLO) begin
        lo <= bus.A;
      end else if (state == ST_ACC) begin
        hi <= acc_result[63:32];
        lo <= acc_result[31:0];
      end
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (accept) begin
      if (bus.OpCode == OP_MFHI) begin
        read_data = hi;
      end else if (bus.OpCode == OP_MFLO) begin
        read_data = lo;
      end
    end
  end

  assign bus.OpReady  = ready;
  assign bus.ReadData = read_data;
  assign bus.Stall    = bus.OpValid & ~ready;
  assign bus.Busy     = (state != ST_IDLE);
  assign bus.Done     = done;
  assign bus.HI       = hi;
  assign bus.LO       = lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_mul_sequencer.sv
//------------------------------------------------------------------------------
// tb_hilo_mul_sequencer: directed vectors on radix-2 and radix-16 instances
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hilo_mul_sequencer;
  import hilo_mul_sequencer_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        iter;
    logic [31:0] exp_rd;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [5:0]  op_code = 6'd0;
  logic [31:0] a_in = 32'd0;
  logic [31:0] b_in = 32'd0;
  int          checks = 0;
  int          errors = 0;
  vec_t        vecs [NV];

  hilo_mul_sequencer_if bus1();
  hilo_mul_sequencer_if bus4();

  assign bus1.OpValid = op_valid;
  assign bus1.OpCode  = op_code;
  assign bus1.A       = a_in;
  assign bus1.B       = b_in;
  assign bus4.OpValid = op_valid;
  assign bus4.OpCode  = op_code;
  assign bus4.A       = a_in;
  assign bus4.B       = b_in;

  hilo_mul_sequencer #(.BITS_PER_CYCLE(1)) dut1 (.Clk(clk), .Rst(rst), .bus(bus1));
  hilo_mul_sequencer #(.BITS_PER_CYCLE(4)) dut4 (.Clk(clk), .Rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one op, check ReadData in its accept cycle, then wait for both to idle.
  task automatic apply(input vec_t v, input int idx);
    int cyc;
    int d1;
    int d4;
    int n1;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = v.op;
    a_in     = v.a;
    b_in     = v.b;
    #1;
    chk($sformatf("v%0d ready1", idx), {63'd0, bus1.OpReady}, 64'd1);
    chk($sformatf("v%0d rd1", idx), {32'd0, bus1.ReadData}, {32'd0, v.exp_rd});
    chk($sformatf("v%0d rd4", idx), {32'd0, bus4.ReadData}, {32'd0, v.exp_rd});
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
    cyc = 0; d1 = 0; d4 = 0; n1 = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus1.Done) begin n1++; d1 = cyc; end
      if (bus4.Done && d4 == 0) d4 = cyc;
      if (!bus1.Busy && !bus4.Busy) break;
    end
    chk($sformatf("v%0d timeout", idx), {63'd0, cyc >= 60}, 64'd0);
    chk($sformatf("v%0d done1 cycle", idx), 64'(d1), v.iter ? 64'd34 : 64'd0);
    chk($sformatf("v%0d done4 cycle", idx), 64'(d4), v.iter ? 64'd10 : 64'd0);
    chk($sformatf("v%0d done1 pulses", idx), 64'(n1), v.iter ? 64'd1 : 64'd0);
    chk($sformatf("v%0d hilo1", idx), {bus1.HI, bus1.LO}, {v.exp_hi, v.exp_lo});
    chk($sformatf("v%0d hilo4", idx), {bus4.HI, bus4.LO}, {v.exp_hi, v.exp_lo});
  endtask

  initial begin
    int   stall_cnt;
    int   done_cnt;
    vec_t v;

    vecs[0]  = '{OP_MTHI,  32'h00000000, 32'h0, 1'b0, 32'h0,        32'h00000000, 32'h00000000};
    vecs[1]  = '{OP_MTLO,  32'h00000005, 32'h0, 1'b0, 32'h0,        32'h00000000, 32'h00000005};
    vecs[2]  = '{OP_MADD,  32'h00000004, 32'hFFFFFFFE, 1'b1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_MFLO,  32'h0, 32'h0, 1'b0, 32'hFFFFFFFD,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{OP_MFHI,  32'h0, 32'h0, 1'b0, 32'hFFFFFFFF,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 1'b1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[6]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'hFFFFFFFE, 32'h00000001};
    vecs[7]  = '{OP_MTHI,  32'h00000000, 32'h0, 1'b0, 32'h0,        32'h00000000, 32'h00000001};
    vecs[8]  = '{OP_MTLO,  32'h00000000, 32'h0, 1'b0, 32'h0,        32'h00000000, 32'h00000000};
    vecs[9]  = '{OP_MSUB,  32'h80000000, 32'h80000000, 1'b1, 32'h0, 32'hC0000000, 32'h00000000};
    vecs[10] = '{OP_MULT,  32'h12345678, 32'h00000002, 1'b1, 32'h0, 32'h00000000, 32'h2468ACF0};
    vecs[11] = '{OP_MADD,  32'h00010000, 32'h00010000, 1'b1, 32'h0, 32'h00000001, 32'h2468ACF0};
    vecs[12] = '{6'b111111, 32'hDEADBEEF, 32'h1, 1'b0, 32'h0,       32'h00000001, 32'h2468ACF0};
    vecs[13] = '{OP_MULT,  32'h80000000, 32'h00000001, 1'b1, 32'h0, 32'hFFFFFFFF, 32'h80000000};
    vecs[14] = '{OP_MULTU, 32'h80000000, 32'h00000002, 1'b1, 32'h0, 32'h00000001, 32'h00000000};
    vecs[15] = '{OP_MSUB,  32'h00000003, 32'h00000005, 1'b1, 32'h0, 32'h00000000, 32'hFFFFFFF1};
    vecs[16] = '{OP_MADD,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h00000000, 32'hFFFFFFF2};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset HI", {32'd0, bus1.HI}, 64'd0);
    chk("reset LO", {32'd0, bus1.LO}, 64'd0);
    chk("reset Busy", {63'd0, bus1.Busy}, 64'd0);
    chk("reset Done", {63'd0, bus1.Done}, 64'd0);
    chk("reset OpReady", {63'd0, bus1.OpReady}, 64'd1);
    chk("reset ReadData", {32'd0, bus1.ReadData}, 64'd0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // MFLO held on OpValid while a MULT runs: stalls until IDLE, then sees new LO.
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = OP_MULT;
    a_in     = 32'h00000100;
    b_in     = 32'h00000300;
    @(posedge clk);
    #1;
    op_code  = OP_MFLO;
    a_in     = 32'h0;
    b_in     = 32'h0;
    stall_cnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!bus1.Stall) break;
      stall_cnt++;
    end
    chk("held MFLO stall cycles", 64'(stall_cnt), 64'd34);
    chk("held MFLO ready", {63'd0, bus1.OpReady}, 64'd1);
    chk("held MFLO ReadData", {32'd0, bus1.ReadData}, 64'h00030000);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    chk("held MFLO hilo4", {bus4.HI, bus4.LO}, 64'h00000000_00030000);

    // Reset at iteration 10 of a MULT on the radix-2 instance.
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = OP_MULT;
    a_in     = 32'h00000005;
    b_in     = 32'h00000006;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre-abort Busy", {63'd0, bus1.Busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("abort Busy", {63'd0, bus1.Busy}, 64'd0);
    chk("abort hilo1", {bus1.HI, bus1.LO}, 64'd0);
    chk("abort hilo4", {bus4.HI, bus4.LO}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus1.Done) done_cnt++;
    end
    chk("abort no Done", 64'(done_cnt), 64'd0);
    chk("abort hilo1 stays 0", {bus1.HI, bus1.LO}, 64'd0);

    v = '{OP_MTHI, 32'h00001234, 32'h0, 1'b0, 32'h0, 32'h00001234, 32'h00000000};
    apply(v, 100);
    v = '{OP_MFHI, 32'h0, 32'h0, 1'b0, 32'h00001234, 32'h00001234, 32'h00000000};
    apply(v, 101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
